// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Sequencing controller for the MM:SS countdown timer. Holds the BCD count,
//   reacts to start/pause/load pulses, runs the tick prescaler, decrements the
//   count once per tick and drives the beeper pattern when the count expires.
//
// Parameters
//   TICK_DIV     clock cycles per count tick (>= 2); also the length of each
//                beep on/off phase
//   BEEP_CYCLES  number of beep on/off pairs played at expiry (>= 1)
//
// Ports
//   clock_i         system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   start_i         pulse: run / resume (acknowledges the alarm)
//   pause_i         pulse: freeze the count (acknowledges the alarm)
//   load_i          pulse: copy clamped preset into the count (acknowledges alarm)
//   preset_min_i    preset minutes, BCD {tens,ones}
//   preset_sec_i    preset seconds, BCD {tens,ones}
//   min_bcd_o       current minutes, BCD
//   sec_bcd_o       current seconds, BCD
//   state_o         IDLE=0, RUN=1, PAUSE=2, ALARM=3, DONE=4
//   running_o       high in RUN
//   done_o          high in ALARM and DONE
//   beep_o          buzzer drive
//
// Build option
//   COUNTDOWN_AUTO_RELOAD_EN  when defined, leaving ALARM reloads the clamped
//                             preset and restarts (or goes to DONE if it is 0).
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned BEEP_CYCLES = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       load_i,
  input  logic [7:0] preset_min_i,
  input  logic [7:0] preset_sec_i,
  output logic [7:0] min_bcd_o,
  output logic [7:0] sec_bcd_o,
  output logic [2:0] state_o,
  output logic       running_o,
  output logic       done_o,
  output logic       beep_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_ALARM = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;          // {min tens, min ones, sec tens, sec ones}
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d; // completed on/off pairs in ALARM
  logic          beep_q, beep_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic [15:0]   preset_clamped;
  logic [15:0]   cnt_dec;
  logic          alarm_exit;

  // Out-of-range BCD digits are saturated rather than rejected.
  function automatic logic [15:0] clamp_preset(input logic [7:0] m, input logic [7:0] s);
    logic [3:0] mt, mo, st, so;
    mt = (m[7:4] > 4'd9) ? 4'd9 : m[7:4];
    mo = (m[3:0] > 4'd9) ? 4'd9 : m[3:0];
    st = (s[7:4] > 4'd5) ? 4'd5 : s[7:4];
    so = (s[3:0] > 4'd9) ? 4'd9 : s[3:0];
    return {mt, mo, st, so};
  endfunction

  // One-second BCD decrement with borrow chain; 00:00 is left unchanged.
  function automatic logic [15:0] dec_count(input logic [15:0] c);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = c;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if ({mt, mo} != 8'h00) begin
      st = 4'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 4'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign preset_clamped = clamp_preset(preset_min_i, preset_sec_i);
  assign cnt_dec        = dec_count(cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    beep_cnt_d = beep_cnt_q;
    beep_d     = beep_q;
    alarm_exit = 1'b0;

    unique case (state_q)
      S_IDLE, S_PAUSE: begin
        if (load_i) begin
          cnt_d      = preset_clamped;
          state_d    = S_IDLE;
          presc_d    = '0;
          beep_d     = 1'b0;
          beep_cnt_d = '0;
        end else if (start_i && (cnt_q != 16'h0000)) begin
          // Prescaler is kept so a resume finishes the interrupted tick.
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (pause_i) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          cnt_d   = cnt_dec;
          if (cnt_dec == 16'h0000) begin
            state_d    = S_ALARM;
            beep_d     = 1'b1;
            beep_cnt_d = '0;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      S_ALARM: begin
        if (start_i || pause_i || load_i) begin
          alarm_exit = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          // Phase boundary: high phase ends -> low, low phase ends -> next pair.
          presc_d = '0;
          if (beep_q) begin
            beep_d = 1'b0;
          end else if (beep_cnt_q == BEEP_LAST) begin
            alarm_exit = 1'b1;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
            beep_d     = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      S_DONE: begin
        if (load_i) begin
          cnt_d      = preset_clamped;
          state_d    = S_IDLE;
          presc_d    = '0;
          beep_d     = 1'b0;
          beep_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (alarm_exit) begin
      beep_d     = 1'b0;
      presc_d    = '0;
      beep_cnt_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      cnt_d   = preset_clamped;
      state_d = (preset_clamped != 16'h0000) ? S_RUN : S_DONE;
`else
      state_d = S_DONE;
`endif
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_ALARM) || (state_d == S_DONE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'h0000;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign min_bcd_o = cnt_q[15:8];
  assign sec_bcd_o = cnt_q[7:0];
  assign state_o   = state_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign beep_o    = beep_q;

endmodule
